// File: rtl/in_port_conditioner_if.sv
// Bus between the input conditioner and the CPU input/output ports.
// raw_in/clr_mask flow into the conditioner; level_out/event_out/irq flow out.
interface in_port_conditioner_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] level_out;
    logic [WIDTH-1:0] event_out;
    logic             irq;

    // CPU / environment side
    modport master (
        output raw_in,
        output clr_mask,
        input  level_out,
        input  event_out,
        input  irq
    );

    // Conditioner side
    modport slave (
        input  raw_in,
        input  clr_mask,
        output level_out,
        output event_out,
        output irq
    );
endinterface

// File: rtl/in_port_conditioner.sv
// Input port conditioner: synchronizer, per-bit debounce, sticky edge flags and irq.
// Optional build macro IN_PORT_FALL_EVENT_EN: event flags set on any level change
// (rise or fall) instead of on rising edges only.
module in_port_conditioner #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input logic                  clk,
    input logic                  reset,
    in_port_conditioner_if.slave bus
);

    localparam int unsigned      CntW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0]  CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [CntW-1:0]  cnt_q  [WIDTH];
    logic [CntW-1:0]  cnt_d  [WIDTH];
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] event_q, event_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] evt_set;

    assign s_q = sync_q[SYNC_STAGES-1];

    // Synchronizer shift chain
    always_comb begin
        sync_d[0] = bus.raw_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Per-bit debounce: count consecutive disagreeing cycles, update level on the last one
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s_q[i] != level_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    level_d[i] = s_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    // Event flags: a set on this edge wins over a clear; irq follows the new flags
    always_comb begin
`ifdef IN_PORT_FALL_EVENT_EN
        evt_set = level_d ^ level_q;
`else
        evt_set = level_d & ~level_q;
`endif
        event_d = evt_set | (event_q & ~bus.clr_mask);
        irq_d   = |event_d;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            level_q <= '0;
            event_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q <= level_d;
            event_q <= event_d;
            irq_q   <= irq_d;
        end
    end

    assign bus.level_out = level_q;
    assign bus.event_out = event_q;
    assign bus.irq       = irq_q;

endmodule

// File: doc/in_port_conditioner.md
Name: in_port_conditioner

Overview:
- Input-side peripheral directly upstream of the CPU input ports.
- Takes raw asynchronous external lines (switches/buttons) through a synchronizer and a per-bit debounce filter.
- Presents the debounced level on a bus wired to in_p0 and sticky rising-edge event flags on a bus wired to in_p1.
- Event flags are cleared by a mask bus driven from a CPU output port (out_p1).

Parameters:
- WIDTH, 8: number of input lines; equals the CPU port width.
- SYNC_STAGES, 2: flip-flop stages in the synchronizer chain, minimum 2.
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before the debounced level changes, minimum 1. Counter width is ceil(log2(DEBOUNCE_CYCLES+1)).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- raw_in  input  WIDTH  asynchronous external lines.
- clr_mask  input  WIDTH  level clear for event flags; driven from out_p1.
- level_out  output  WIDTH  debounced level; drives in_p0.
- event_out  output  WIDTH  sticky rising-edge flags; drives in_p1.
- irq  output  1  OR-reduction of event_out, registered.

Behaviour:
- Reset (reset==0 at an edge): all synchronizer stages, debounce counters, level_out, event_out and irq go to 0. Reset overrides all other activity, including mid-debounce and mid-clear. Outputs are 0 in the cycle after the reset edge.
- Synchronizer: raw_in shifts through SYNC_STAGES registers; s_q is the last stage. A raw change held stable reaches s_q after SYNC_STAGES edges.
- Debounce, per bit i, independent:
  - If s_q[i]==level_out[i]: cnt[i]<=0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1: level_out[i]<=s_q[i], cnt[i]<=0.
  - Else: cnt[i]<=cnt[i]+1.
- Debounce latency: with defaults, a raw change stable before edge 1 shows on level_out after edge 6 (SYNC_STAGES+DEBOUNCE_CYCLES). With DEBOUNCE_CYCLES=1, the update is at edge SYNC_STAGES+1.
- Glitch rejection: any return of s_q[i] to level_out[i] before the count completes resets cnt[i] to 0. A glitch shorter than DEBOUNCE_CYCLES never changes level_out.
- Rise detection: rise[i] is true on the edge where level_out[i] updates 0->1.
- Event update per bit: event_out[i] <= rise[i] | (event_out[i] & ~clr_mask[i]).
  - Set wins over a simultaneous clear.
  - A held clr_mask bit clears every cycle but never blocks a new rise.
  - A bit already 1 stays 1 on a repeat rise; there is no counting.
- irq <= |(next value of event_out), so irq changes on the same edge as event_out.
- No combinational path from any input to any output.

Optional Feature:
- Macro: IN_PORT_FALL_EVENT_EN.
- Defined: rise[i] is replaced by a change detect, true on any level_out[i] update, 0->1 or 1->0. Set/clear priority and irq behaviour are unchanged.
- Undefined: only 0->1 transitions set event flags; falling transitions update level_out only.

Test Plan:
- Reset: hold reset=0 for 3 edges with raw_in=8'hFF and clr_mask=0 -> level_out=8'h00, event_out=8'h00, irq=0 throughout. Then release reset with raw_in=8'hFF held -> level_out=8'hFF and event_out=8'hFF after the 6th edge following release; irq=1 on the same edge.
- Latency: raw_in 8'h00->8'h01 stable before edge 1 -> level_out=8'h00 after edge 5; level_out=8'h01, event_out=8'h01, irq=1 after edge 6.
- Glitch: raw_in[3] high for exactly 3 cycles, then low -> level_out and event_out unchanged. Repeat with 4 cycles -> level_out[3] pulses to 1 and event_out[3] latches 1.
- Clear: with event_out=8'h05, clr_mask=8'h04 for 1 cycle -> event_out=8'h01, irq stays 1. Then clr_mask=8'h01 -> event_out=8'h00, irq=0 on the same edge.
- Set/clear collision: clr_mask=8'h02 held while level_out[1] updates 0->1 -> event_out[1]=1 after that edge and 0 after the next edge.
- Falling input: raw_in[0] 1->0 stable -> level_out[0]=0 six edges later. event_out[0] stays 0 without IN_PORT_FALL_EVENT_EN; event_out[0]=1 with the macro defined.
